// File: rtl/tmds_decoder.sv
// TMDS channel decoder with word-alignment tracking.
// Decodes 10-bit TMDS words, hunts for control-token runs to lock, and requests bit slips.
module tmds_decoder #(
  parameter int TOKEN_RUN      = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int SLIP_SETTLE    = 16,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] q_in,
  output logic [7:0] D,
  output logic       C0,
  output logic       C1,
  output logic       DE,
  output logic       locked,
  output logic       bitslip,
  output logic       lock_lost,
  output logic [1:0] state_dbg
);

  localparam int RW = (TOKEN_RUN      > 1) ? $clog2(TOKEN_RUN)      : 1;
  localparam int TW = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
  localparam int SW = (SLIP_SETTLE    > 1) ? $clog2(SLIP_SETTLE)    : 1;
  localparam int LW = (LOSS_TIMEOUT   > 1) ? $clog2(LOSS_TIMEOUT)   : 1;

  localparam logic [RW-1:0] RUN_LAST    = RW'(TOKEN_RUN - 1);
  localparam logic [TW-1:0] TMR_LAST    = TW'(SEARCH_TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SLIP_SETTLE - 1);
  localparam logic [LW-1:0] LOSS_LAST   = LW'(LOSS_TIMEOUT - 1);

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH    = 2'd0,
    SLIP_WAIT = 2'd1,
    LOCKED    = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [RW-1:0] run_cnt, run_nx;
  logic [TW-1:0] srch_tmr, srch_nx;
  logic [SW-1:0] settle_cnt, settle_nx;
  logic [LW-1:0] loss_cnt, loss_nx;
  logic          bitslip_nx, lost_nx;

  logic          is_tok;
  logic [1:0]    tok_c;
  logic [7:0]    d_unx;
  logic [7:0]    dec;

  assign state_dbg = state;

  always_comb begin
    is_tok = 1'b1;
    tok_c  = 2'b00;
    case (q_in)
      TOK_00:  tok_c = 2'b00;
      TOK_01:  tok_c = 2'b01;
      TOK_10:  tok_c = 2'b10;
      TOK_11:  tok_c = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    d_unx  = q_in[9] ? ~q_in[7:0] : q_in[7:0];
    dec    = 8'h00;
    dec[0] = d_unx[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = q_in[8] ? (d_unx[i] ^ d_unx[i-1]) : ~(d_unx[i] ^ d_unx[i-1]);
    end
  end

  always_comb begin
    state_nx   = state;
    run_nx     = run_cnt;
    srch_nx    = srch_tmr;
    settle_nx  = settle_cnt;
    loss_nx    = loss_cnt;
    bitslip_nx = 1'b0;
    lost_nx    = 1'b0;
    case (state)
      SEARCH: begin
        srch_nx = (srch_tmr == {TW{1'b1}}) ? srch_tmr : srch_tmr + TW'(1);
        if (is_tok) run_nx = (run_cnt == {RW{1'b1}}) ? run_cnt : run_cnt + RW'(1);
        else        run_nx = '0;
        // A completed run takes priority over a simultaneous timeout.
        if (is_tok && run_cnt == RUN_LAST) begin
          state_nx = LOCKED;
          run_nx   = '0;
          srch_nx  = '0;
          loss_nx  = '0;
        end else if (srch_tmr == TMR_LAST) begin
          state_nx   = SLIP_WAIT;
          bitslip_nx = 1'b1;
          run_nx     = '0;
          srch_nx    = '0;
          settle_nx  = '0;
        end
      end
      SLIP_WAIT: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nx  = SEARCH;
          settle_nx = '0;
          run_nx    = '0;
          srch_nx   = '0;
        end else begin
          settle_nx = settle_cnt + SW'(1);
        end
      end
      LOCKED: begin
        if (is_tok) begin
          loss_nx = '0;
        end else if (loss_cnt == LOSS_LAST) begin
          state_nx = SEARCH;
          lost_nx  = 1'b1;
          loss_nx  = '0;
          run_nx   = '0;
          srch_nx  = '0;
        end else begin
          loss_nx = loss_cnt + LW'(1);
        end
      end
      default: state_nx = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEARCH;
      run_cnt    <= '0;
      srch_tmr   <= '0;
      settle_cnt <= '0;
      loss_cnt   <= '0;
      bitslip    <= 1'b0;
      lock_lost  <= 1'b0;
      locked     <= 1'b0;
      D          <= 8'h00;
      DE         <= 1'b0;
      C0         <= 1'b0;
      C1         <= 1'b0;
    end else begin
      state      <= state_nx;
      run_cnt    <= run_nx;
      srch_tmr   <= srch_nx;
      settle_cnt <= settle_nx;
      loss_cnt   <= loss_nx;
      bitslip    <= bitslip_nx;
      lock_lost  <= lost_nx;
      // Outputs follow the state being entered, so the lock-completing word decodes as locked.
      if (state_nx == LOCKED) begin
        locked <= 1'b1;
        if (is_tok) begin
          DE       <= 1'b0;
          D        <= 8'h00;
          {C1, C0} <= tok_c;
        end else begin
          DE <= 1'b1;
          D  <= dec;
        end
      end else begin
        locked <= 1'b0;
        D      <= 8'h00;
        DE     <= 1'b0;
        C0     <= 1'b0;
        C1     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: lock, decode, loss, bit slip and reset behaviour.
// Expected outputs are queued at stimulus time and checked by an independent monitor.
module tb_tmds_decoder;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] ROT = 10'b1010101001;
  localparam logic [9:0] W00 = 10'b0100000000;
  localparam int         W   = 14;
  localparam logic [W-1:0] Z = '0;

  logic       clk;
  logic       rst;
  logic [9:0] q_in;
  logic [7:0] D;
  logic       C0, C1, DE, locked, bitslip, lock_lost;
  logic [1:0] state_dbg;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           disp     = 0;

  tmds_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .q_in      (q_in),
    .D         (D),
    .C0        (C0),
    .C1        (C1),
    .DE        (DE),
    .locked    (locked),
    .bitslip   (bitslip),
    .lock_lost (lock_lost),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst  = 1'b1;
    q_in = T00;
  end

  function automatic logic [W-1:0] ev(input logic lk, input logic bs, input logic ll,
                                      input logic de, input logic [1:0] c, input logic [7:0] d);
    return {lk, bs, ll, de, c, d};
  endfunction

  // Reference DVI TMDS data encoder with running disparity.
  function automatic logic [9:0] enc(input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] q;
    int n1, n1q, n0q;
    n1 = $countones(d);
    qm = '0;
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (disp == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      if (qm[8]) disp = disp + n1q - n0q;
      else       disp = disp + n0q - n1q;
    end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      disp = disp + (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      disp = disp - (qm[8] ? 0 : 2) + n1q - n0q;
    end
    return q;
  endfunction

  // Driver: one word per cycle, expected post-edge outputs queued alongside.
  task automatic drive(input logic r, input logic [9:0] w, input logic [W-1:0] e, input string nm);
    @(negedge clk);
    rst  = r;
    q_in = w;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic drive_n(input int n, input logic [9:0] w, input logic [W-1:0] e, input string nm);
    for (int i = 0; i < n; i++) drive(1'b0, w, e, nm);
  endtask

  // Monitor / scoreboard
  initial begin
    logic [W-1:0] e, act;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {locked, bitslip, lock_lost, DE, C1, C0, D};
        n_checks++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s @%0t: got lk/bs/ll/de/c/d=%h required %h", nm, $time, act, e);
        end
      end
    end
  end

  initial begin
    // Reset and initial lock on {C1,C0}=00 tokens
    drive(1'b1, T00, Z, "reset");
    drive(1'b1, T11, Z, "reset");
    drive_n(7, T00, Z, "search_run");
    drive(1'b0, T00, ev(1, 0, 0, 0, 2'b00, 8'h00), "lock");

    // Data zero, control tracking, control hold across data
    drive(1'b0, W00, ev(1, 0, 0, 1, 2'b00, 8'h00), "data_zero");
    drive(1'b0, T01, ev(1, 0, 0, 0, 2'b01, 8'h00), "tok01");
    drive(1'b0, T10, ev(1, 0, 0, 0, 2'b10, 8'h00), "tok10");
    drive(1'b0, T11, ev(1, 0, 0, 0, 2'b11, 8'h00), "tok11");
    drive(1'b0, W00, ev(1, 0, 0, 1, 2'b11, 8'h00), "c_hold");

    // Full byte sweep through the reference encoder
    disp = 0;
    for (int b = 0; b < 256; b++)
      drive(1'b0, enc(8'(b)), ev(1, 0, 0, 1, 2'b11, 8'(b)), "sweep");

    // Loss of lock after LOSS_TIMEOUT data-only words, then relock
    drive(1'b0, T00, ev(1, 0, 0, 0, 2'b00, 8'h00), "tok00");
    for (int k = 1; k < 4096; k++)
      drive(1'b0, enc(8'(k)), ev(1, 0, 0, 1, 2'b00, 8'(k)), "loss_hold");
    drive(1'b0, enc(8'h5a), ev(0, 0, 1, 0, 2'b00, 8'h00), "lock_lost");
    drive(1'b0, enc(8'h33), Z, "after_loss");
    drive_n(7, T10, Z, "relock_run");
    drive(1'b0, T10, ev(1, 0, 0, 0, 2'b10, 8'h00), "relock");

    // Reset while locked needs a full new run
    drive(1'b1, T10, Z, "rst_locked");
    drive_n(7, T10, Z, "post_rst_run");
    drive(1'b0, T10, ev(1, 0, 0, 0, 2'b10, 8'h00), "post_rst_lock");

    // A non-token word restarts the run
    drive(1'b1, T00, Z, "reset");
    drive_n(5, T00, Z, "partial_run");
    drive(1'b0, enc(8'h81), Z, "run_break");
    drive_n(7, T00, Z, "run_again");
    drive(1'b0, T00, ev(1, 0, 0, 0, 2'b00, 8'h00), "lock_after_break");

    // Lock completing on the timeout cycle wins over the slip
    drive(1'b1, ROT, Z, "reset");
    drive_n(2040, ROT, Z, "tie_search");
    drive_n(7, T01, Z, "tie_run");
    drive(1'b0, T01, ev(1, 0, 0, 0, 2'b01, 8'h00), "tie_lock_wins");
    drive(1'b0, T01, ev(1, 0, 0, 0, 2'b01, 8'h00), "tie_no_slip");

    // Bit slip on timeout, settle window ignores tokens, timer restarts
    drive(1'b1, ROT, Z, "reset");
    drive_n(2047, ROT, Z, "slip_search");
    drive(1'b0, ROT, ev(0, 1, 0, 0, 2'b00, 8'h00), "bitslip");
    drive_n(16, T00, Z, "slip_wait");
    drive_n(2047, ROT, Z, "search_restart");
    drive(1'b0, ROT, ev(0, 1, 0, 0, 2'b00, 8'h00), "bitslip_again");
    drive_n(5, T00, Z, "slip_wait2");
    drive(1'b1, T00, Z, "rst_slip_wait");
    drive_n(7, T00, Z, "post_slip_rst_run");
    drive(1'b0, T00, ev(1, 0, 0, 0, 2'b00, 8'h00), "lock_after_slip_rst");

    // Drain: monitor must have consumed every expectation within a few cycles
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tmds_decoder.md
TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 Parameter TOKEN_RUN, default 8: consecutive control tokens needed to declare lock.
REQ-002 Parameter SEARCH_TIMEOUT, default 2048: cycles in SEARCH without lock before a bit slip is requested.
REQ-003 Parameter SLIP_SETTLE, default 16: cycles waited after a bit slip before searching resumes.
REQ-004 Parameter LOSS_TIMEOUT, default 4096: cycles in LOCKED without any control token before lock is dropped.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 q_in  input  10  raw TMDS word from the deserializer; q_in[9] is the invert flag, q_in[8] is the XOR/XNOR flag.
REQ-008 D  output  8  decoded pixel byte.
REQ-009 C0  output  1  decoded control bit 0.
REQ-010 C1  output  1  decoded control bit 1.
REQ-011 DE  output  1  data enable; 1 for data period words, 0 for control tokens.
REQ-012 locked  output  1  word alignment achieved.
REQ-013 bitslip  output  1  one-cycle pulse asking the deserializer to shift word alignment by one bit.
REQ-014 lock_lost  output  1  one-cycle pulse when LOCKED drops to SEARCH because of timeout.

Function
REQ-015 Control tokens ({C1,C0} -> q_in): 00 -> 1101010100, 01 -> 0010101011, 10 -> 0101010100, 11 -> 1010101011.
REQ-016 Data decode: d = q_in[9] ? ~q_in[7:0] : q_in[7:0]; D[0] = d[0]; for i = 1..7, D[i] = q_in[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
REQ-017 Latency is one cycle: a word present on q_in before rising edge N appears on D/C0/C1/DE after edge N; all outputs are registered.
REQ-018 When locked=1 and the word is a control token: DE=0, {C1,C0} set per REQ-015, D=0.
REQ-019 When locked=1 and the word is not a control token: DE=1, D per REQ-016, C0/C1 hold their last values.
REQ-020 When locked=0: D=0, DE=0, C0=0, C1=0 regardless of q_in.
REQ-021 FSM states: SEARCH, SLIP_WAIT, LOCKED.
REQ-022 SEARCH: the run counter increments on each control token and clears on each non-token word; the timer increments every cycle.
REQ-023 SEARCH -> LOCKED when the run counter reaches TOKEN_RUN; locked rises on that same edge, and the word completing the run is decoded as locked.
REQ-024 SEARCH -> SLIP_WAIT when the timer reaches SEARCH_TIMEOUT-1 without lock; bitslip=1 for exactly that one cycle; timer and run counter clear.
REQ-025 If lock completion and timeout occur on the same cycle, lock wins and no bitslip is issued.
REQ-026 SLIP_WAIT: q_in is ignored for SLIP_SETTLE cycles, then the FSM returns to SEARCH with counters cleared; no further bitslip is asserted during SLIP_WAIT.
REQ-027 LOCKED: the loss timer clears on every control token and otherwise increments.
REQ-028 LOCKED -> SEARCH when the loss timer reaches LOSS_TIMEOUT-1; locked falls and lock_lost=1 for one cycle on that edge.
REQ-029 Counters are sized with $clog2 of their parameter and saturate; none wraps to zero other than by the clears defined above.

Reset
REQ-030 While rst=1 at a rising edge: state=SEARCH, all counters=0, D=0, C0=0, C1=0, DE=0, locked=0, bitslip=0, lock_lost=0.
REQ-031 rst asserted mid-operation (including during a bitslip pulse or in SLIP_WAIT) takes effect on the next edge; no pulse output survives it.

Verification
REQ-032 Reset, then drive 8 consecutive tokens for {C1,C0}=00 -> locked=1 after the 8th edge; DE=0, C0=C1=0.
REQ-033 Locked: drive the encoded word 0100000000 (value 0x00) -> next cycle D=0x00, DE=1; drive the tokens for {C1,C0}=01, 10, 11 -> C1C0 tracks each with 1-cycle latency, DE=0.
REQ-034 Locked: sweep all 256 bytes through a reference TMDS encoder (DE=1) -> D equals each input byte one cycle later, with no lock loss.
REQ-035 Drive a bit-rotated token stream (no valid token) for 2048 cycles -> bitslip single pulse at cycle 2048, no pulse for the next 16 cycles, the search timer restarts from 0.
REQ-036 Locked, then data-only words for 4096 cycles -> lock_lost pulse and locked=0 on cycle 4096, outputs forced to 0; 8 tokens later locked=1 again.
REQ-037 Assert rst for 1 cycle while locked -> all outputs 0 on the next edge, and relock needs a full 8-token run.
